// File: rtl/alu_wb_seq.sv
// Execute/writeback sequencer: latches one operation, runs it (1 cycle, or 16 for MUL),
// then drives the register-group write port for a single cycle.
module alu_wb_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [15:0] opA,
    input  logic [15:0] opB,
    input  logic [3:0]  dst,
    output logic        busy,
    output logic        done,
    output logic        regwr,
    output logic [3:0]  w_addr,
    output logic [15:0] result,
    output logic        zero
);

    // Handshake: start is sampled only in IDLE; busy covers EXEC/MUL/WB, and
    // done/regwr are a single-cycle pulse during WB. Starts while busy are dropped.
    typedef enum logic [1:0] {IDLE, EXEC, MUL, WB} state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    state_t      stateQ, stateD;
    logic [2:0]  opQ;
    logic [15:0] mcand;
    logic [15:0] mplier;
    logic [15:0] acc;
    logic [3:0]  mulCnt;
    logic [3:0]  dstQ;
    logic [15:0] resultQ;
    logic        zeroQ;
    logic [15:0] aluOut;
    logic [15:0] mulSum;

    always_ff @(posedge clk) begin
        if (!rst_n) stateQ <= IDLE;
        else        stateQ <= stateD;
    end

    always_comb begin
        stateD = stateQ;
        case (stateQ)
            IDLE:    if (start) stateD = (op == OP_MUL) ? MUL : EXEC;
            EXEC:    stateD = WB;
            MUL:     if (mulCnt == 4'd15) stateD = WB;
            WB:      stateD = IDLE;
            default: stateD = IDLE;
        endcase
    end

    // Outside MUL, mcand/mplier simply hold the latched opA/opB.
    always_comb begin
        aluOut = 16'h0000;
        case (opQ)
            OP_ADD:  aluOut = mcand + mplier;
            OP_SUB:  aluOut = mcand - mplier;
            OP_AND:  aluOut = mcand & mplier;
            OP_OR:   aluOut = mcand | mplier;
            OP_XOR:  aluOut = mcand ^ mplier;
            OP_SLL:  aluOut = mcand << mplier[3:0];
            OP_SRL:  aluOut = mcand >> mplier[3:0];
            default: aluOut = 16'h0000;
        endcase
    end

    assign mulSum = acc + (mplier[0] ? mcand : 16'h0000);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            opQ     <= 3'b000;
            mcand   <= 16'h0000;
            mplier  <= 16'h0000;
            acc     <= 16'h0000;
            mulCnt  <= 4'd0;
            dstQ    <= 4'd0;
            resultQ <= 16'h0000;
            zeroQ   <= 1'b1;
        end else begin
            case (stateQ)
                IDLE: begin
                    if (start) begin
                        opQ    <= op;
                        mcand  <= opA;
                        mplier <= opB;
                        dstQ   <= dst;
                        acc    <= 16'h0000;
                        mulCnt <= 4'd0;
                    end
                end
                EXEC: begin
                    resultQ <= aluOut;
                    zeroQ   <= (aluOut == 16'h0000);
                end
                MUL: begin
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    mulCnt <= mulCnt + 4'd1;
                    // The last iteration's sum goes straight to result.
                    if (mulCnt == 4'd15) begin
                        resultQ <= mulSum;
                        zeroQ   <= (mulSum == 16'h0000);
                    end else begin
                        acc <= mulSum;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy   = (stateQ != IDLE);
    assign done   = (stateQ == WB);
    assign regwr  = (stateQ == WB);
    assign w_addr = dstQ;
    assign result = resultQ;
    assign zero   = zeroQ;

endmodule

// File: tb/tb_alu_wb_seq.sv
// Bench for alu_wb_seq: directed vectors plus random ops against a plain-arithmetic model.
module tb_alu_wb_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [15:0] opA;
  logic [15:0] opB;
  logic [3:0]  dst;
  logic        busy;
  logic        done;
  logic        regwr;
  logic [3:0]  w_addr;
  logic [15:0] result;
  logic        zero;

  int checks = 0;
  int failures = 0;

  alu_wb_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .opA(opA), .opB(opB), .dst(dst),
    .busy(busy), .done(done), .regwr(regwr), .w_addr(w_addr), .result(result), .zero(zero)
  );

  // clock/reset block
  always #5 clk = ~clk;

  // reference model: the architectural result of one op
  function automatic logic [15:0] model(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    logic [3:0]  sh;
    sh = b[3:0];
    p  = a * b;
    case (o)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return a << sh;
      3'd6: return a >> sh;
      default: return p[15:0];
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] o);
    return (o == 3'd7) ? 17 : 2;
  endfunction

  // driver: issue one op with a one-cycle start, scramble inputs afterwards, observe WB
  task automatic do_op(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b, input logic [3:0] d,
                       output int lat, output int busyCnt, output logic [15:0] res, output logic z,
                       output logic [3:0] wa, output logic dn, output logic busyAfter, output logic regwrAfter);
    @(negedge clk);
    op = o; opA = a; opB = b; dst = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op = 3'($urandom); opA = 16'($urandom); opB = 16'($urandom); dst = 4'($urandom);
    lat = 1;
    busyCnt = 0;
    while (regwr !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) busyCnt++;
      @(negedge clk);
      lat++;
    end
    if (busy === 1'b1) busyCnt++;
    res = result; z = zero; wa = w_addr; dn = done;
    @(negedge clk);
    busyAfter = busy;
    regwrAfter = regwr;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; op = 3'd0; opA = 16'h0; opB = 16'h0; dst = 4'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (regwr !== 1'b0) begin failures++; $display("FAIL reset_regwr got=%b exp=0", regwr); end
    checks++; if (w_addr !== 4'd0) begin failures++; $display("FAIL reset_waddr got=%h exp=0", w_addr); end
    checks++; if (result !== 16'h0) begin failures++; $display("FAIL reset_result got=%h exp=0000", result); end
    checks++; if (zero !== 1'b1) begin failures++; $display("FAIL reset_zero got=%b exp=1", zero); end
  endtask

  task automatic test_add();
    int lat, bc; logic [15:0] res; logic z, dn, ba, ra; logic [3:0] wa;
    do_op(3'd0, 16'h7FFF, 16'h0001, 4'd3, lat, bc, res, z, wa, dn, ba, ra);
    checks++; if (lat !== 2) begin failures++; $display("FAIL add_latency got=%0d exp=2", lat); end
    checks++; if (bc !== 2) begin failures++; $display("FAIL add_busy_cycles got=%0d exp=2", bc); end
    checks++; if (res !== 16'h8000) begin failures++; $display("FAIL add_result got=%h exp=8000", res); end
    checks++; if (z !== 1'b0) begin failures++; $display("FAIL add_zero got=%b exp=0", z); end
    checks++; if (wa !== 4'd3) begin failures++; $display("FAIL add_waddr got=%h exp=3", wa); end
    checks++; if (dn !== 1'b1) begin failures++; $display("FAIL add_done got=%b exp=1", dn); end
    checks++; if (ba !== 1'b0 || ra !== 1'b0) begin failures++; $display("FAIL add_after_wb busy=%b regwr=%b exp=0/0", ba, ra); end
  endtask

  // directed table: SUB, shifts and MUL boundary cases
  task automatic test_directed();
    logic [2:0]  tOp [11];
    logic [15:0] tA  [11];
    logic [15:0] tB  [11];
    logic [15:0] tExp[11];
    int lat, bc; logic [15:0] res; logic z, dn, ba, ra; logic [3:0] wa;
    tOp = '{3'd1, 3'd1, 3'd5, 3'd6, 3'd6, 3'd7, 3'd7, 3'd7, 3'd2, 3'd3, 3'd4};
    tA  = '{16'h1234, 16'h0000, 16'h0001, 16'h8000, 16'hBEEF, 16'h0123, 16'hFFFF, 16'h0100, 16'hF0F0, 16'hF000, 16'hAAAA};
    tB  = '{16'h1234, 16'h0001, 16'hFFF4, 16'h000F, 16'hFFF0, 16'h0045, 16'hFFFF, 16'h0100, 16'h0FF0, 16'h000F, 16'hFFFF};
    tExp = '{16'h0000, 16'hFFFF, 16'h0010, 16'h0001, 16'hBEEF, 16'h4E6F, 16'h0001, 16'h0000, 16'h00F0, 16'hF00F, 16'h5555};
    for (int i = 0; i < 11; i++) begin
      logic [3:0] d;
      d = 4'(i + 4);
      do_op(tOp[i], tA[i], tB[i], d, lat, bc, res, z, wa, dn, ba, ra);
      checks++; if (res !== tExp[i]) begin failures++; $display("FAIL dir%0d_result got=%h exp=%h", i, res, tExp[i]); end
      checks++; if (z !== (tExp[i] == 16'h0)) begin failures++; $display("FAIL dir%0d_zero got=%b exp=%b", i, z, tExp[i] == 16'h0); end
      checks++; if (lat !== model_lat(tOp[i])) begin failures++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, model_lat(tOp[i])); end
      checks++; if (wa !== d) begin failures++; $display("FAIL dir%0d_waddr got=%h exp=%h", i, wa, d); end
      checks++; if (ba !== 1'b0 || ra !== 1'b0) begin failures++; $display("FAIL dir%0d_after_wb busy=%b regwr=%b exp=0/0", i, ba, ra); end
    end
  endtask

  task automatic test_random();
    int lat, bc; logic [15:0] res, exp; logic z, dn, ba, ra; logic [3:0] wa;
    for (int i = 0; i < 40; i++) begin
      logic [2:0] o; logic [15:0] a, b; logic [3:0] d;
      o = 3'($urandom_range(0, 7)); a = 16'($urandom); b = 16'($urandom); d = 4'($urandom_range(0, 15));
      if (i % 8 == 0) b = 16'h0;
      exp = model(o, a, b);
      do_op(o, a, b, d, lat, bc, res, z, wa, dn, ba, ra);
      checks++;
      if (res !== exp || z !== (exp == 16'h0) || wa !== d || lat !== model_lat(o) || bc !== model_lat(o) || ba !== 1'b0) begin
        failures++;
        $display("FAIL rand%0d op=%0d a=%h b=%h got res=%h z=%b wa=%h lat=%0d busy=%0d exp res=%h wa=%h lat=%0d",
                 i, o, a, b, res, z, wa, lat, bc, exp, d, model_lat(o));
      end
    end
  endtask

  task automatic test_busy_reject();
    int cyc; logic [15:0] res; logic [3:0] wa;
    @(negedge clk);
    op = 3'd7; opA = 16'h0123; opB = 16'h0045; dst = 4'd5; start = 1'b1;
    @(negedge clk);
    cyc = 1;
    res = 16'hxxxx; wa = 4'hx;
    // hold start high with churning operands through MUL and WB
    while (cyc < 40) begin
      if (regwr === 1'b1) begin res = result; wa = w_addr; end
      op = 3'($urandom); opA = 16'($urandom); opB = 16'($urandom); dst = 4'($urandom);
      if (regwr === 1'b1) break;
      @(negedge clk);
      cyc++;
    end
    checks++; if (cyc !== 17) begin failures++; $display("FAIL busy_rej_latency got=%0d exp=17", cyc); end
    checks++; if (res !== 16'h4E6F || wa !== 4'd5) begin failures++; $display("FAIL busy_rej_result got=%h/%h exp=4e6f/5", res, wa); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || regwr !== 1'b0) begin failures++; $display("FAIL busy_rej_idle busy=%b regwr=%b exp=0/0", busy, regwr); end
    op = 3'd0; opA = 16'h1111; opB = 16'h2222; dst = 4'd12;
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL busy_rej_accept busy=%b exp=1", busy); end
    @(negedge clk);
    checks++; if (regwr !== 1'b1 || result !== 16'h3333 || w_addr !== 4'd12) begin
      failures++; $display("FAIL busy_rej_second regwr=%b res=%h wa=%h exp=1/3333/c", regwr, result, w_addr);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat, bc; logic [15:0] res; logic z, dn, ba, ra; logic [3:0] wa;
    do_op(3'd4, 16'h00FF, 16'h0F0F, 4'd0, lat, bc, res, z, wa, dn, ba, ra);
    do_op(3'd3, 16'h0000, 16'h0000, 4'd15, lat, bc, res, z, wa, dn, ba, ra);
    checks++; if (res !== 16'h0 || z !== 1'b1 || wa !== 4'd15) begin
      failures++; $display("FAIL b2b_or_zero got=%h/%b/%h exp=0000/1/f", res, z, wa);
    end
  endtask

  task automatic test_reset_abort();
    int lat, bc; logic [15:0] res; logic z, dn, ba, ra; logic [3:0] wa;
    logic sawWr;
    @(negedge clk);
    op = 3'd7; opA = 16'h1234; opB = 16'h5678; dst = 4'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || regwr !== 1'b0 || w_addr !== 4'd0 || result !== 16'h0 || zero !== 1'b1) begin
      failures++;
      $display("FAIL abort_outputs busy=%b done=%b regwr=%b wa=%h res=%h zero=%b exp=0/0/0/0/0000/1",
               busy, done, regwr, w_addr, result, zero);
    end
    sawWr = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (regwr === 1'b1) sawWr = 1'b1;
    end
    checks++; if (sawWr !== 1'b0) begin failures++; $display("FAIL abort_no_regwr got=%b exp=0", sawWr); end
    do_op(3'd2, 16'hF0F0, 16'h0FF0, 4'd7, lat, bc, res, z, wa, dn, ba, ra);
    checks++; if (res !== 16'h00F0 || lat !== 2 || wa !== 4'd7) begin
      failures++; $display("FAIL abort_then_and got=%h lat=%0d wa=%h exp=00f0 lat=2 wa=7", res, lat, wa);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_directed();
    test_random();
    test_busy_reject();
    test_back_to_back();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
